// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the CPU clock step controller.
package clk_ctrl_pkg;

    // Run-control state of the CPU clock enable generator.
    typedef enum logic [1:0] {
        PAUSED    = 2'd0,
        RUNNING   = 2'd1,
        STEP_WAIT = 2'd2
    } step_state_t;

    // Flop depth of every asynchronous-input synchroniser in this block.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low pushbutton.
// pressed_lvl is the accepted (debounced) level, 1 = pressed.
// press_evt is a 1-cycle pulse on each accepted released->pressed change.
module key_debounce
    import clk_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic refclk,
    input  logic reset,
    input  logic key_n,
    output logic pressed_lvl,
    output logic press_evt
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LOAD = CW'(DEB_CYCLES - 1);

    // Synchroniser carries the pressed polarity so its reset value of 0
    // reads as "released" and cannot fake a press after reset.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw_pressed;
    logic [CW-1:0]          deb_cnt;

    assign raw_pressed = sync_q[SYNC_STAGES-1];

    // Two-flop synchroniser on the inverted key input.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ~key_n};
        end
    end

    // Down-counter restarts whenever the raw level agrees with the accepted
    // level; the accepted level flips on terminal count of a disagreeing run.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            deb_cnt     <= DEB_LOAD;
            pressed_lvl <= 1'b0;
            press_evt   <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (raw_pressed == pressed_lvl) begin
                deb_cnt <= DEB_LOAD;
            end else if (deb_cnt == '0) begin
                deb_cnt     <= DEB_LOAD;
                pressed_lvl <= raw_pressed;
                press_evt   <= raw_pressed;
            end else begin
                deb_cnt <= deb_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_clock_step_ctrl.sv
// CPU clock enable generator with run / pause / single-step keys.
// Turns each rising edge of the divided clock into a one-refclk cpu_en
// pulse while the controller is running or waiting for a single step,
// and counts issued pulses for the display.
// Optional breakpoint build: define CLK_STEP_BREAK_EN to pause once the
// pulse that makes cycle_count equal bp_value has been issued.
//
// state     | meaning
// ----------+------------------------------------------------------
// PAUSED    | no pulses; waiting for a run or step key press
// RUNNING   | one cpu_en pulse per divided-clock rising edge
// STEP_WAIT | issue exactly one pulse on the next tick, then PAUSED
module cpu_clock_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES   = 500000,
    parameter int CNT_W        = 16,
    parameter bit RUN_AT_RESET = 1'b0
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             div_clk,
    input  logic             key_run_n,
    input  logic             key_step_n,
    input  logic [CNT_W-1:0] bp_value,
    output logic             cpu_en,
    output logic             running,
    output logic             step_pending,
    output logic [CNT_W-1:0] cycle_count
);

    localparam step_state_t RESET_STATE = RUN_AT_RESET ? RUNNING : PAUSED;

    logic [SYNC_STAGES-1:0] div_sync;
    logic                   div_prev;
    logic                   tick;

    logic                   run_evt;
    logic                   step_evt;
    logic                   run_lvl_unused;
    logic                   step_lvl_unused;

    step_state_t            state;
    step_state_t            state_nxt;
    logic                   en_nxt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   brk_hit;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_run_key (
        .refclk      (refclk),
        .reset       (reset),
        .key_n       (key_run_n),
        .pressed_lvl (run_lvl_unused),
        .press_evt   (run_evt)
    );

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_key (
        .refclk      (refclk),
        .reset       (reset),
        .key_n       (key_step_n),
        .pressed_lvl (step_lvl_unused),
        .press_evt   (step_evt)
    );

    // Synchronise the divided clock and keep one cycle of history for the edge detect.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            div_sync <= '0;
            div_prev <= 1'b0;
        end else begin
            div_sync <= {div_sync[SYNC_STAGES-2:0], div_clk};
            div_prev <= div_sync[SYNC_STAGES-1];
        end
    end

    assign tick    = div_sync[SYNC_STAGES-1] & ~div_prev;
    assign cnt_inc = cycle_count + CNT_W'(1);

`ifdef CLK_STEP_BREAK_EN
    assign brk_hit = (bp_value != '0) && (cnt_inc == bp_value);
`else
    logic bp_unused;
    assign bp_unused = ^bp_value;
    assign brk_hit   = 1'b0;
`endif

    // Next-state and pulse decision; a run press always wins and discards
    // any tick or step press seen in the same cycle.
    always_comb begin
        state_nxt = state;
        en_nxt    = 1'b0;
        case (state)
            PAUSED: begin
                if (run_evt) begin
                    state_nxt = RUNNING;
                end else if (step_evt) begin
                    state_nxt = STEP_WAIT;
                end
            end
            RUNNING: begin
                if (run_evt) begin
                    state_nxt = PAUSED;
                end else if (tick) begin
                    en_nxt = 1'b1;
                    if (brk_hit) begin
                        state_nxt = PAUSED;
                    end
                end
            end
            STEP_WAIT: begin
                if (run_evt) begin
                    state_nxt = RUNNING;
                end else if (tick) begin
                    en_nxt    = 1'b1;
                    state_nxt = PAUSED;
                end
            end
            default: begin
                state_nxt = PAUSED;
            end
        endcase
    end

    // State register, registered enable pulse and executed-cycle counter.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state       <= RESET_STATE;
            cpu_en      <= 1'b0;
            cycle_count <= '0;
        end else begin
            state  <= state_nxt;
            cpu_en <= en_nxt;
            if (en_nxt) begin
                cycle_count <= cnt_inc;
            end
        end
    end

    assign running      = (state == RUNNING);
    assign step_pending = (state == STEP_WAIT);

endmodule

// File: tb/tb_cpu_clock_step_ctrl.sv
// Directed bench for cpu_clock_step_ctrl (DEB_CYCLES=4, CNT_W=4,
// divided clock period 10 refclk). Breakpoint checks follow CLK_STEP_BREAK_EN.
module tb_cpu_clock_step_ctrl;

    logic       refclk = 1'b0;
    logic       reset;
    logic       div_clk;
    logic       key_run_n;
    logic       key_step_n;
    logic [3:0] bp_value;
    logic       cpu_en;
    logic       running;
    logic       step_pending;
    logic [3:0] cycle_count;

    int n_chk    = 0;
    int n_fail   = 0;
    int cycles   = 0;
    int pulses   = 0;
    int rise_cyc = 0;
    int ph       = 0;
    bit div_on   = 1'b0;

    typedef struct {
        logic       div;
        logic       run_n;
        logic       step_n;
        logic       en;
        logic       run;
        logic       pend;
        logic [3:0] cnt;
    } vec_t;

    vec_t vec [22];

    cpu_clock_step_ctrl #(
        .DEB_CYCLES   (4),
        .CNT_W        (4),
        .RUN_AT_RESET (1'b0)
    ) dut (
        .refclk       (refclk),
        .reset        (reset),
        .div_clk      (div_clk),
        .key_run_n    (key_run_n),
        .key_step_n   (key_step_n),
        .bp_value     (bp_value),
        .cpu_en       (cpu_en),
        .running      (running),
        .step_pending (step_pending),
        .cycle_count  (cycle_count)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One refclk cycle: sample #1 after the edge, then advance the divided clock.
    task automatic cyc();
        @(posedge refclk);
        #1;
        cycles++;
        if (cpu_en) begin
            pulses++;
            if (div_on) chk("tick_latency", cycles - rise_cyc, 3);
        end
        if (div_on) begin
            if (ph == 0) rise_cyc = cycles;
            div_clk = (ph < 5);
            ph = (ph == 9) ? 0 : ph + 1;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press_run(input int len);
        key_run_n = 1'b0;
        run_cycles(len);
        key_run_n = 1'b1;
    endtask

    task automatic press_step(input int len);
        key_step_n = 1'b0;
        run_cycles(len);
        key_step_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit pend_seen;

        // Run press, first two ticks and an ignored step press while RUNNING.
        //           div   run_n step_n en    run   pend  cnt
        vec[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vec[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vec[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vec[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vec[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vec[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vec[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
        vec[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
        vec[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
        vec[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
        vec[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        vec[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        vec[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        vec[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        vec[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        vec[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        vec[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2};
        vec[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};

        reset      = 1'b1;
        div_clk    = 1'b0;
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        bp_value   = 4'd0;
        run_cycles(3);
        chk("rst_cpu_en", int'(cpu_en), 0);
        chk("rst_count", int'(cycle_count), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_step_pending", int'(step_pending), 0);
        reset = 1'b0;

        // 1: paused after reset, five divided-clock periods produce nothing.
        ph = 0;
        div_on = 1'b1;
        run_cycles(50);
        chk("t1_pulses", pulses, 0);
        chk("t1_count", int'(cycle_count), 0);
        chk("t1_running", int'(running), 0);
        div_on  = 1'b0;
        div_clk = 1'b0;
        run_cycles(10);

        // 2: table-driven run press and tick latency, then run to wrap.
        for (int r = 0; r < 22; r++) begin
            div_clk    = vec[r].div;
            key_run_n  = vec[r].run_n;
            key_step_n = vec[r].step_n;
            cyc();
            chk($sformatf("vec%0d_cpu_en", r), int'(cpu_en), int'(vec[r].en));
            chk($sformatf("vec%0d_running", r), int'(running), int'(vec[r].run));
            chk($sformatf("vec%0d_step_pending", r), int'(step_pending), int'(vec[r].pend));
            chk($sformatf("vec%0d_count", r), int'(cycle_count), int'(vec[r].cnt));
        end
        ph = 5;
        div_on = 1'b1;
        for (int i = 0; i < 400 && pulses < 17; i++) cyc();
        chk("t2_pulses", pulses, 17);
        chk("t2_wrap_count", int'(cycle_count), 1);
        chk("t2_running", int'(running), 1);

        // 3: pause, then single step with a second (ignored) step press.
        press_run(6);
        run_cycles(10);
        chk("t3_paused", int'(running), 0);
        p0 = pulses;
        run_cycles(30);
        chk("t3_paused_pulses", pulses - p0, 0);
        div_on  = 1'b0;
        div_clk = 1'b0;
        run_cycles(5);
        press_step(6);
        cyc();
        chk("t3_step_pending", int'(step_pending), 1);
        run_cycles(8);
        press_step(6);
        run_cycles(4);
        chk("t3_step_still_pending", int'(step_pending), 1);
        chk("t3_step_not_running", int'(running), 0);
        p0 = pulses;
        ph = 0;
        div_on = 1'b1;
        run_cycles(40);
        chk("t3_step_pulses", pulses - p0, 1);
        chk("t3_step_done", int'(step_pending), 0);
        chk("t3_step_paused", int'(running), 0);
        run_cycles(30);
        chk("t3_no_queued_step", pulses - p0, 1);

        // 4: simultaneous presses -> run wins; short glitch -> no event.
        pend_seen = 1'b0;
        key_run_n  = 1'b0;
        key_step_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (step_pending) pend_seen = 1'b1;
        end
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (step_pending) pend_seen = 1'b1;
        end
        chk("t4_running", int'(running), 1);
        chk("t4_step_discarded", int'(pend_seen), 0);
        press_run(3);
        run_cycles(12);
        chk("t4_glitch_ignored", int'(running), 1);
        p0 = pulses;
        run_cycles(20);
        chk("t4_still_pulsing", int'((pulses - p0) >= 1), 1);

        // 5: reset one cycle after a tick; the in-flight pulse must vanish.
        for (int i = 0; i < 40 && (cycles - rise_cyc) != 2; i++) cyc();
        chk("t5_tick_aligned", cycles - rise_cyc, 2);
        reset = 1'b1;
        #1;
        chk("t5_count_async", int'(cycle_count), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t5_cpu_en_%0d", i), int'(cpu_en), 0);
        end
        chk("t5_running", int'(running), 0);
        reset = 1'b0;
        p0 = pulses;
        run_cycles(30);
        chk("t5_after_pulses", pulses - p0, 0);
        chk("t5_after_count", int'(cycle_count), 0);

        // 6: breakpoint at 5 (or bp_value ignored in the default build).
        bp_value = 4'd5;
        p0 = pulses;
        press_run(6);
`ifdef CLK_STEP_BREAK_EN
        run_cycles(120);
        chk("t6_break_pulses", pulses - p0, 5);
        chk("t6_break_count", int'(cycle_count), 5);
        chk("t6_break_paused", int'(running), 0);
`else
        for (int i = 0; i < 150 && (pulses - p0) < 7; i++) cyc();
        chk("t6_nobreak_pulses", pulses - p0, 7);
        chk("t6_nobreak_count", int'(cycle_count), 7);
        chk("t6_nobreak_running", int'(running), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
